// File: rtl/encoder8to3.sv
// Sequential 8-to-3 encoder: latches request lines into a pending mask and
// offers one pending index per valid/ready handshake. Define ROUND_ROBIN_EN for rotating priority.
module encoder8to3 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_req,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [2:0] o_addr,
  output logic [7:0] o_pending,
  output logic [3:0] o_count
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d, clr;
  logic [3:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic [2:0] addr_q, addr_d;
  logic       hs;
  logic [2:0] sel_cur, sel_next;

  function automatic logic [3:0] popcnt(input logic [7:0] m);
    popcnt = '0;
    for (int i = 0; i < 8; i++) popcnt = popcnt + 4'(m[i]);
  endfunction

`ifdef ROUND_ROBIN_EN
  logic [2:0] last_q, last_d;

  // Search starts just above the base index and wraps; base itself is checked last.
  function automatic logic [2:0] sel_rr(input logic [7:0] m, input logic [2:0] base);
    logic [2:0] idx;
    logic       found;
    sel_rr = '0;
    found  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = base + 3'(k);
      if (!found && m[idx]) begin
        sel_rr = idx;
        found  = 1'b1;
      end
    end
  endfunction

  always_comb begin
    last_d   = hs ? addr_q : last_q;
    sel_cur  = sel_rr(pend_q, last_q);
    sel_next = sel_rr(pend_d, last_d);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) last_q <= 3'd7;
    else       last_q <= last_d;
  end
`else
  function automatic logic [2:0] sel_fix(input logic [7:0] m);
    sel_fix = '0;
    for (int i = 7; i >= 0; i--) if (m[i]) sel_fix = 3'(i);
  endfunction

  always_comb begin
    sel_cur  = sel_fix(pend_q);
    sel_next = sel_fix(pend_d);
  end
`endif

  // A re-request in the handshake cycle wins over the clear.
  always_comb begin
    hs     = valid_q & i_ready;
    clr    = hs ? (8'b1 << addr_q) : 8'b0;
    pend_d = (pend_q & ~clr) | i_req;
    cnt_d  = popcnt(pend_d);
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (pend_q != 8'b0) begin
          addr_d  = sel_cur;
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (i_ready) begin
          if (pend_d != 8'b0) begin
            addr_d = sel_next;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_addr    = addr_q;
  assign o_pending = pend_q;
  assign o_count   = cnt_q;

endmodule

// File: tb/tb_encoder8to3.sv
// Bench for encoder8to3: directed per-cycle vector table plus randomized traffic
// compared against a pending-set reference model.
module tb_encoder8to3;

`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_req = 8'h00;
  logic       i_ready = 1'b0;
  logic       o_valid;
  logic [2:0] o_addr;
  logic [7:0] o_pending;
  logic [3:0] o_count;

  int checks = 0;
  int failures = 0;

  encoder8to3 dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_ready(i_ready),
    .o_valid(o_valid), .o_addr(o_addr), .o_pending(o_pending), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic       ev;
    logic [2:0] ea;
    logic [7:0] ep;
    logic [3:0] ec;
  } vec_t;

  vec_t tbl[$];

  // Reference: the pending set and the offered index, tracked as integers.
  int  m_pend, m_valid, m_addr, m_last;
  bit  m_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int m, input int base);
    if (RR) begin
      for (int k = 1; k <= 8; k++) if (m[(base + k) % 8]) return (base + k) % 8;
    end else begin
      for (int k = 0; k < 8; k++) if (m[k]) return k;
    end
    return 0;
  endfunction

  function automatic int ones(input int m);
    int n = 0;
    for (int k = 0; k < 8; k++) n += m[k];
    return n;
  endfunction

  // Advance one clock: predict from the inputs applied this cycle, then compare.
  task automatic tick();
    int np, nv, na, nl;
    bit hs;
    np = m_pend; nv = m_valid; na = m_addr; nl = m_last;
    if (i_rst) begin
      np = 0; nv = 0; na = 0; nl = 7;
    end else begin
      hs = (m_valid != 0) && i_ready;
      np = m_pend;
      if (hs) begin
        np = np - (np & (1 << m_addr));
        nl = m_addr;
      end
      np = np | int'(i_req);
      if (m_valid == 0) begin
        if (m_pend != 0) begin
          nv = 1;
          na = pick(m_pend, m_last);
        end
      end else if (hs) begin
        if (np != 0) na = pick(np, nl);
        else nv = 0;
      end
    end
    @(posedge i_clk);
    #1;
    if (i_rst) m_ok = 1'b1;
    m_pend = np; m_valid = nv; m_addr = na; m_last = nl;
    if (m_ok) begin
      chk("model_valid", o_valid, m_valid);
      chk("model_pending", o_pending, m_pend);
      chk("model_count", o_count, ones(m_pend));
      if (m_valid != 0) chk("model_addr", o_addr, m_addr);
    end
  endtask

  task automatic add(input logic rst, input logic [7:0] req, input logic rdy,
                     input logic ev, input logic [2:0] ea, input logic [7:0] ep,
                     input logic [3:0] ec);
    vec_t v;
    v.rst = rst; v.req = req; v.rdy = rdy; v.ev = ev; v.ea = ea; v.ep = ep; v.ec = ec;
    tbl.push_back(v);
  endtask

  initial begin
    // reset with everything asserted
    add(1, 8'hFF, 1, 0, 0, 8'h00, 0);
    add(1, 8'hFF, 1, 0, 0, 8'h00, 0);
    // single request
    add(0, 8'h10, 1, 0, 0, 8'h10, 1);
    add(0, 8'h00, 1, 1, 4, 8'h10, 1);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0);
    // burst drain
    add(1, 8'h00, 0, 0, 0, 8'h00, 0);
    add(0, 8'hA5, 1, 0, 0, 8'hA5, 4);
    add(0, 8'h00, 1, 1, 0, 8'hA5, 4);
    add(0, 8'h00, 1, 1, 2, 8'hA4, 3);
    add(0, 8'h00, 1, 1, 5, 8'hA0, 2);
    add(0, 8'h00, 1, 1, 7, 8'h80, 1);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0);
    // backpressure
    add(1, 8'h00, 0, 0, 0, 8'h00, 0);
    add(0, 8'h08, 0, 0, 0, 8'h08, 1);
    add(0, 8'h00, 0, 1, 3, 8'h08, 1);
    add(0, 8'h01, 0, 1, 3, 8'h09, 2);
    add(0, 8'h00, 0, 1, 3, 8'h09, 2);
    add(0, 8'h00, 0, 1, 3, 8'h09, 2);
    add(0, 8'h00, 1, 1, 0, 8'h01, 1);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0);
    // set/clear collision
    add(1, 8'h00, 0, 0, 0, 8'h00, 0);
    add(0, 8'h08, 1, 0, 0, 8'h08, 1);
    add(0, 8'h00, 1, 1, 3, 8'h08, 1);
    add(0, 8'h08, 1, 1, 3, 8'h08, 1);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0);
    // held 0x81, then mid-stream reset
    add(1, 8'h00, 0, 0, 0, 8'h00, 0);
    add(0, 8'h81, 1, 0, 0, 8'h81, 2);
    add(0, 8'h81, 1, 1, 0, 8'h81, 2);
    add(0, 8'h81, 1, 1, RR ? 3'd7 : 3'd0, 8'h81, 2);
    add(0, 8'h81, 1, 1, 0, 8'h81, 2);
    add(0, 8'h81, 1, 1, RR ? 3'd7 : 3'd0, 8'h81, 2);
    add(1, 8'h81, 1, 0, 0, 8'h00, 0);
    add(0, 8'h81, 1, 0, 0, 8'h81, 2);
    add(0, 8'h00, 1, 1, 0, 8'h81, 2);
    add(0, 8'h00, 1, 1, 7, 8'h80, 1);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0);
    // ready while idle has no effect
    add(0, 8'h00, 1, 0, 0, 8'h00, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      i_rst = tbl[i].rst; i_req = tbl[i].req; i_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), o_valid, tbl[i].ev);
      chk($sformatf("vec%0d_pending", i), o_pending, tbl[i].ep);
      chk($sformatf("vec%0d_count", i), o_count, tbl[i].ec);
      if (tbl[i].ev || tbl[i].rst) chk($sformatf("vec%0d_addr", i), o_addr, tbl[i].ea);
    end

    // all-ones request reaches a count of eight
    i_rst = 0; i_req = 8'hFF; i_ready = 0;
    tick();
    chk("allones_count", o_count, 4'd8);
    i_req = 8'h00; i_ready = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("allones_drained", o_count, 4'd0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      i_rst   = ($urandom_range(0, 60) == 0);
      i_req   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      i_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    // held requests with random readiness
    i_rst = 0;
    for (int i = 0; i < 200; i++) begin
      i_req   = 8'h81 | (($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00);
      i_ready = ($urandom_range(0, 1) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder8to3.md
# encoder8to3

Sequential 8-to-3 encoder, the inverse of the 3-to-8 address decoder. It latches eight one-bit select/request lines into a pending register and emits the 3-bit index of each pending line, one per handshake. It sits where several select lines are collected back into a binary address, such as interrupt or event sources mapped onto a shared address bus, and feeds a downstream consumer over a valid/ready interface.

## Interface
- No parameters. Width is fixed at 8 lines and 3 address bits.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  8  request/select lines; bit k requests address k. Multiple bits may be set in any cycle.
- i_ready  in  1  consumer accepts o_addr when i_ready and o_valid are both high.
- o_valid  out  1  o_addr holds a valid pending index.
- o_addr  out  3  encoded index being offered.
- o_pending  out  8  registered pending mask P.
- o_count  out  4  registered popcount of P, range 0..8.

## Operation
- **Pending register P[7:0].**
  - Every cycle: P ← (P & ~C) | i_req.
  - C is the one-hot mask of o_addr when o_valid & i_ready; otherwise C = 0.
  - Set wins over clear on the same bit: a re-request in the handshake cycle leaves the bit pending.
- **o_count** ← popcount of next P, registered together with P, so o_count always matches o_pending.
- **FSM, two states:**
  - IDLE: o_valid = 0. If P ≠ 0, load o_addr = sel(P), set o_valid = 1 and go to OFFER. Otherwise stay in IDLE.
  - OFFER: o_valid = 1.
    - If i_ready = 0: hold o_addr and o_valid. New requests update P but never change o_addr.
    - If i_ready = 1 and P_next ≠ 0: load o_addr = sel(P_next) and stay in OFFER. This gives back-to-back grants at one per cycle.
    - If i_ready = 1 and P_next = 0: go to IDLE and clear o_valid.
- **sel(M):** returns the lowest set index of M (fixed priority). The ROUND_ROBIN_EN macro changes this (see Configuration).
- **Reset:** synchronous; takes precedence over all other inputs.
  - Reset values: P = 0, o_pending = 0, o_count = 0, o_valid = 0, o_addr = 0, FSM = IDLE, last-grant pointer L = 7.
  - i_req during a reset cycle is dropped. A handshake in a reset cycle is discarded.
- **All-ones input:** i_req = 8'hFF sets o_count = 8, so o_count needs 4 bits.

## Timing
- i_req asserted in cycle n sets P at edge n+1; o_valid rises at edge n+2 if the FSM was in IDLE. Request-to-valid latency is 2 cycles.
- A handshake in cycle m clears the bit at edge m+1 and presents the next index in the same edge; the encoder never adds a bubble between grants.
- o_valid and o_addr are registered outputs. o_valid never drops without a handshake, except on reset.
- i_ready may be asserted while o_valid = 0; it has no effect.

## Configuration
- **ROUND_ROBIN_EN defined:**
  - Pointer L is updated to o_addr on each handshake.
  - sel(M) searches from index (L+1) mod 8 upward, wrapping through 7 → 0.
  - A held request cannot starve other pending bits.
- **ROUND_ROBIN_EN undefined:**
  - L is not implemented.
  - sel(M) is fixed lowest-index priority.
  - A continuously asserted low bit starves higher bits; this is accepted behaviour.

## Test plan
- **Reset:** i_rst = 1 for 2 cycles with i_req = 8'hFF and i_ready = 1 → o_valid = 0, o_addr = 0, o_pending = 0, o_count = 0 throughout. The first cycle after reset still shows P = 0.
- **Single request:** i_req = 8'h10 for one cycle, i_ready = 1 → two edges later o_valid = 1 and o_addr = 4 for exactly one cycle; o_count goes 1 → 0; FSM returns to IDLE.
- **Burst drain, fixed priority:** i_req = 8'hA5 for one cycle, i_ready = 1 → o_addr = 0, 2, 5, 7 on consecutive cycles; o_count = 4, 3, 2, 1, 0; o_valid drops after index 7.
- **Backpressure:**
  - i_req = 8'h08, then i_ready = 0 for 4 cycles with i_req = 8'h01 pulsed → o_addr stays 3 and o_pending = 8'h09.
  - Release i_ready → grants 3, then 0.
- **Set/clear collision:** i_req = 8'h08 pulsed again in the cycle o_addr = 3 is accepted → bit 3 stays pending; o_addr = 3 is offered again on the next cycle; o_count stays 1.
- **Round-robin and mid-operation reset:**
  - i_req = 8'h81 held, i_ready = 1 → with ROUND_ROBIN_EN: 0, 7, 0, 7; without it: 0, 0, 0, 0.
  - Asserting i_rst mid-stream clears everything. The first grant after reset is 0; with ROUND_ROBIN_EN this is because L = 7.
